seq_detector_prog: RTL
======================

Name: seq_detector_prog

Overview:
Runtime-programmable serial bit-pattern detector. It is the parametrised successor of the fixed 5-bit Moore detectors.
- Pattern bits, pattern length (1..MAX_LEN) and overlap mode are loaded at run time.
- Input bits are qualified by a valid strobe.
- A saturating match counter is kept.
- Sits between a serial bit source (deserialiser or UART RX) and control logic that reacts to framing or sync words.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..16)
LEN_W, $clog2(MAX_LEN+1), width of length and progress fields
CNT_W, 8, width of the match counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
load  in  1  config strobe; captures pattern, len, overlap
pattern  in  MAX_LEN  pattern bits; pattern[len-1] is the first bit expected, pattern[0] the last
len  in  LEN_W  pattern length; legal range 1..MAX_LEN
overlap  in  1  1 = overlapping matches allowed, 0 = history cleared after each match
X  in  1  serial data bit
x_valid  in  1  X is consumed on a rising edge when high
Z  out  1  Moore match output; high while the progress state equals len_r
Q  out  LEN_W  progress state: number of leading pattern bits currently matched
armed  out  1  configuration valid, detector active
cfg_err  out  1  last load had len==0 or len>MAX_LEN
match_count  out  CNT_W  number of matches, saturating at all-ones

Behaviour:
- Reset (async, immediate) clears the following to 0: pat_r, len_r, ovl_r, the history shift register, hist_cnt, Q, Z, armed, cfg_err, match_count.
- After reset the detector is disarmed until the first legal load.
- Config load on a clock edge with load=1:
  - pat_r, len_r and ovl_r capture their inputs.
  - History, hist_cnt and Q clear.
  - match_count is not cleared.
  - armed = (1<=len<=MAX_LEN); cfg_err = !armed.
- Disarmed: X and x_valid are ignored; Q=0 and Z=0 hold.
- Load and x_valid in the same cycle: load wins and the bit is dropped.
- Bit accept (armed, x_valid=1, load=0):
  - hist <= {hist[MAX_LEN-2:0], X}.
  - hist_cnt increments, saturating at MAX_LEN.
  - Q_next = largest k, 0<=k<=min(len_r, hist_cnt+1), such that the newest k history bits (including X) equal pat_r[len_r-1 -: k].
  - This is an exhaustive priority compare, highest k first, computed combinationally.
- Match: Q_next==len_r. Registered, so Z rises the cycle after the edge that accepted the last pattern bit (latency 1 from the final bit's edge). match_count increments on that same edge unless already saturated.
- While in the match state:
  - overlap=1: the next accepted bit is evaluated against the full retained history, so suffix reuse is allowed.
  - overlap=0: the history is treated as empty (hist_cnt cleared on the match edge), so the next Q is computed from the new bit alone.
- Idle cycle (x_valid=0): Q, hist and Z hold. Z stays high in the match state until the next accepted bit (pure Moore).
- len_r=1: every accepted bit equal to pat_r[0] is a match. Z stays high across consecutive matching bits.
- Reset mid-stream: all state is lost and the detector disarms; no partial match survives.
- Q width is LEN_W. Q never exceeds len_r.

Test Plan:
1. Reset, then x_valid pulses → armed=0, Z=0, match_count=0. Load len=0 → cfg_err=1, armed=0.
2. Load pattern=8'b0000_1101 (01101), len=5, overlap=1; stream 0,1,1,0,1,1,0,1 → Q sequence 1,2,3,4,5,3,4,5; Z high after the 5th and 8th bits; match_count=2.
3. Same stream with overlap=0 → Q sequence 1,2,3,4,5,0,1,2; single Z pulse; match_count=1.
4. 01101 loaded; stream 0,1,1 with x_valid low for 4 cycles, then 0,1 → Q holds at 3 during the gap; match on the final bit.
5. Load mid-pattern (Q=3) together with x_valid=1 → bit dropped; Q=0 next cycle; match_count unchanged. CNT_W=2: 4 matches → count stays at 3.
6. Pattern 8'b1111_1111, len=8, overlap=1; ten consecutive 1s → Z rises after bit 8 and stays high through bits 9 and 10; match_count=3.

Source files
------------

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector: Moore match flag, progress state and saturating match counter.
// Q and Z register on the edge that accepts a bit; a load on the same edge wins and the bit is dropped.
module seq_detector_prog #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               overlap,
  input  logic               X,
  input  logic               x_valid,
  output logic               Z,
  output logic [LEN_W-1:0]   Q,
  output logic               armed,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   match_count
);

  logic [MAX_LEN-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic               ovl_r;
  // Only MAX_LEN-1 past bits are stored; the incoming bit completes the window.
  logic [MAX_LEN-2:0] hist;
  logic [LEN_W-1:0]   hist_cnt;

  logic [MAX_LEN-1:0] new_hist;
  logic [LEN_W-1:0]   q_next;
  logic               accept;
  logic               hit;
  logic               cfg_ok;

  assign accept   = armed & x_valid & ~load;
  assign new_hist = {hist, X};
  assign cfg_ok   = (len != '0) && (len <= LEN_W'(MAX_LEN));
  assign hit      = (q_next == len_r);

  // Longest pattern prefix that ends on the newest bit; ascending scan so the largest k wins.
  always_comb begin
    q_next = '0;
    for (int k = 1; k <= MAX_LEN; k++) begin
      if ((LEN_W'(k) <= len_r) && (LEN_W'(k - 1) <= hist_cnt) &&
          ((((pat_r >> (len_r - LEN_W'(k))) ^ new_hist) &
            ({MAX_LEN{1'b1}} >> (MAX_LEN - k))) == '0)) begin
        q_next = LEN_W'(k);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_r       <= '0;
      len_r       <= '0;
      ovl_r       <= 1'b0;
      hist        <= '0;
      hist_cnt    <= '0;
      Q           <= '0;
      Z           <= 1'b0;
      armed       <= 1'b0;
      cfg_err     <= 1'b0;
      match_count <= '0;
    end else if (load) begin
      pat_r    <= pattern;
      len_r    <= len;
      ovl_r    <= overlap;
      hist     <= '0;
      hist_cnt <= '0;
      Q        <= '0;
      Z        <= 1'b0;
      armed    <= cfg_ok;
      cfg_err  <= ~cfg_ok;
    end else if (accept) begin
      hist <= new_hist[MAX_LEN-2:0];
      Q    <= q_next;
      Z    <= hit;
      if (hit && !ovl_r) begin
        hist_cnt <= '0;
      end else if (hist_cnt != LEN_W'(MAX_LEN)) begin
        hist_cnt <= hist_cnt + 1'b1;
      end
      if (hit && (match_count != {CNT_W{1'b1}})) begin
        match_count <= match_count + 1'b1;
      end
    end
  end

endmodule
